// File: rtl/gate_multi_fault_queued_if.sv
// Handshake bundle for gate_multi_fault_queued: gate inputs, mode select and fault trigger
// in one direction; pass pulse, queue status and overflow flag in the other.
interface gate_multi_fault_queued_if #(
    parameter int INPUT_COUNT = 2,
    parameter int QUEUE_DEPTH = 4
);
    localparam int PEND_W = $clog2(QUEUE_DEPTH + 1);

    logic [INPUT_COUNT-1:0] in;
    logic [1:0]             mode;
    logic                   fault_in;
    logic                   out;
    logic                   busy;
    logic                   overflow;
    logic [PEND_W-1:0]      pending;

    modport master (
        output in, mode, fault_in,
        input  out, busy, overflow, pending
    );

    modport slave (
        input  in, mode, fault_in,
        output out, busy, overflow, pending
    );
endinterface

// File: rtl/gate_multi_fault_queued.sv
// Faulty multi-input gate: fault_in pulses queue as triggers, each serviced by a small FSM that
// pulses out on a pass. Define GATE_FAULT_DET_MODES_EN to enable the AND/OR/XOR modes.
module gate_multi_fault_queued #(
    parameter int                    INPUT_COUNT = 2,
    parameter int                    LFSR_WIDTH  = 12,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = 12'h829,
    parameter logic [LFSR_WIDTH-1:0] RAND_SEED   = 12'hAAA,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic logic_reset,
    gate_multi_fault_queued_if.slave bus
);
    localparam int PEND_W = $clog2(QUEUE_DEPTH + 1);
    localparam int CNT_W  = $clog2(INPUT_COUNT + 1);
    localparam logic [LFSR_WIDTH-1:0] LFSR_MAX = '1;
    localparam logic [LFSR_WIDTH-1:0] STEP     = LFSR_MAX / LFSR_WIDTH'(INPUT_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_PULSE} state_t;

    state_t                 state_q, state_d;
    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [LFSR_WIDTH-1:0]  threshold_q, threshold_d;
    logic [INPUT_COUNT-1:0] in_q, in_d;
    logic [1:0]             mode_q, mode_d;
    logic [1:0]             mode_sel;
    logic [PEND_W-1:0]      pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_W-1:0]       ones;
    logic                   pass;
    logic                   inc;
    logic                   dec;

`ifdef GATE_FAULT_DET_MODES_EN
    assign mode_sel = bus.mode;
`else
    // Mode port kept for pin compatibility; every trigger takes the weighted-random path.
    logic unused_mode;
    assign unused_mode = ^bus.mode;
    assign mode_sel    = 2'd0;
`endif

    always_comb begin
        ones = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            ones = ones + CNT_W'(bus.in[i]);
        end
    end

    // An all-zero register would stick forever, so it is reseeded instead of shifted.
    always_comb begin
        if (lfsr_q == '0) begin
            lfsr_d = RAND_SEED;
        end else begin
            lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_comb begin
        in_d        = in_q;
        mode_d      = mode_q;
        threshold_d = threshold_q;
        if ((bus.in != in_q) || (mode_sel != mode_q)) begin
            in_d        = bus.in;
            mode_d      = mode_sel;
            threshold_d = LFSR_WIDTH'(ones) * STEP;
        end
    end

    always_comb begin
        case (mode_q)
            2'd1:    pass = &in_q;
            2'd2:    pass = |in_q;
            2'd3:    pass = ^in_q;
            default: pass = (lfsr_q < threshold_q);
        endcase
    end

    assign inc = bus.fault_in;
    assign dec = (state_q == S_IDLE) && (pending_q != '0);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE:  if (pending_q != '0) state_d = S_EVAL;
            S_EVAL:  state_d = pass ? S_PULSE : S_IDLE;
            S_PULSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (inc && !dec) begin
            if (pending_q == PEND_W'(QUEUE_DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!inc && dec) begin
            pending_d = pending_q - 1'b1;
        end
        // Trigger path clear wins over any same-cycle trigger, which is silently dropped.
        if (logic_reset) begin
            state_d    = S_IDLE;
            pending_d  = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= RAND_SEED;
            threshold_q <= '0;
            in_q        <= '0;
            mode_q      <= 2'd0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            threshold_q <= threshold_d;
            in_q        <= in_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out      = (state_q == S_PULSE);
    assign bus.busy     = (state_q != S_IDLE) || (pending_q != '0);
    assign bus.overflow = overflow_q;
    assign bus.pending  = pending_q;
endmodule

// File: tb/tb_gate_multi_fault_queued.sv
// Randomised and directed bench for gate_multi_fault_queued, checked every cycle against a
// trigger-scheduling reference model; a second pair of 4-input instances covers pass rate.
module tb_gate_multi_fault_queued;
    localparam int          IC   = 2;
    localparam int          QD   = 4;
    localparam logic [11:0] TAPS = 12'h829;
    localparam logic [11:0] SEED = 12'hAAA;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic lrst = 1'b0;
    logic lrst4 = 1'b0;
    always #5 clk = ~clk;

    gate_multi_fault_queued_if #(.INPUT_COUNT(IC), .QUEUE_DEPTH(QD)) bus ();
    gate_multi_fault_queued_if #(.INPUT_COUNT(4), .QUEUE_DEPTH(QD)) bus4a ();
    gate_multi_fault_queued_if #(.INPUT_COUNT(4), .QUEUE_DEPTH(QD)) bus4b ();

    gate_multi_fault_queued #(.INPUT_COUNT(IC), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset_n), .logic_reset(lrst), .bus(bus));
    gate_multi_fault_queued #(.INPUT_COUNT(4), .QUEUE_DEPTH(QD)) u4a (
        .clk(clk), .reset(reset_n), .logic_reset(lrst4), .bus(bus4a));
    gate_multi_fault_queued #(.INPUT_COUNT(4), .QUEUE_DEPTH(QD)) u4b (
        .clk(clk), .reset(reset_n), .logic_reset(lrst4), .bus(bus4b));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the server is free from interval m_free_at on; a trigger taken at
    // edge k is evaluated with the values of interval k and, on pass, pulses in interval k+1.
    int          k = 0;
    logic [11:0] m_lfsr = SEED;
    logic [1:0]  m_in_q = '0;
    logic [1:0]  m_mode_q = '0;
    int          m_pend = 0;
    int          m_free_at = 0;
    int          m_out_at = -1;
    bit          m_ovf = 1'b0;
    bit          m_inc, m_dec;

    function automatic logic [11:0] lfsr_step(input logic [11:0] x);
        logic fb;
        fb = 1'b0;
        if (x == 12'h000) return SEED;
        for (int b = 0; b < 12; b++) if (TAPS[b]) fb = fb ^ x[b];
        return {x[10:0], fb};
    endfunction

    function automatic bit model_pass(input logic [1:0] md, input logic [1:0] iq,
                                      input logic [11:0] lf);
        int thr;
        thr = $countones(iq) * (4095 / IC);
        case (md)
            2'd1:    return &iq;
            2'd2:    return |iq;
            2'd3:    return ^iq;
            default: return int'(lf) < thr;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k = 0; m_lfsr = SEED; m_in_q = '0; m_mode_q = '0;
            m_pend = 0; m_free_at = 0; m_out_at = -1; m_ovf = 1'b0;
        end else begin
            k++;
            m_lfsr = lfsr_step(m_lfsr);
            m_in_q = bus.in;
`ifdef GATE_FAULT_DET_MODES_EN
            m_mode_q = bus.mode;
`else
            m_mode_q = 2'd0;
`endif
            m_inc = bus.fault_in;
            if (lrst) begin
                m_pend = 0; m_free_at = k; m_out_at = -1; m_ovf = 1'b0;
            end else begin
                m_dec = (k - 1 >= m_free_at) && (m_pend > 0);
                if (m_dec) begin
                    if (model_pass(m_mode_q, m_in_q, m_lfsr)) begin
                        m_out_at = k + 1; m_free_at = k + 2;
                    end else begin
                        m_free_at = k + 1;
                    end
                end
                if (m_inc && !m_dec && m_pend == QD) m_ovf = 1'b1;
                else m_pend = m_pend + int'(m_inc) - int'(m_dec);
            end
        end
    end

    always @(negedge clk) begin
        check("out", bus.out, (m_out_at == k));
        check("busy", bus.busy, (k < m_free_at) || (m_pend != 0));
        check("pending", bus.pending, m_pend);
        check("overflow", bus.overflow, m_ovf);
        check("out_4a_vs_4b", bus4a.out, bus4b.out);
    end

    bit cnt_en = 0;
    bit rate_en = 0;
    int busy_cnt, out_cnt, max_pend, rate_cnt, ncyc;
    int pulse_at[$];

    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (cnt_en) begin
            busy_cnt += int'(bus.busy);
            out_cnt  += int'(bus.out);
            if (bus.out) pulse_at.push_back(ncyc);
            if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
        end
        if (rate_en) rate_cnt += int'(bus4a.out);
    endtask

    task automatic clear_counts();
        busy_cnt = 0; out_cnt = 0; max_pend = 0; pulse_at.delete();
    endtask

    task automatic wait_idle(input bit four);
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = four ? !bus4a.busy : !bus.busy;
        end
        if (!done) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic drive(input logic [1:0] in_v, input logic [1:0] md, input logic f);
        bus.in = in_v; bus.mode = md; bus.fault_in = f;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pattern;
        bit spacing_ok;
        drive(2'b00, 2'd0, 1'b0);
        bus4a.in = '0; bus4a.mode = '0; bus4a.fault_in = 1'b0;
        bus4b.in = '0; bus4b.mode = '0; bus4b.fault_in = 1'b0;
        repeat (3) tick();
        check("reset_out", bus.out, 0);
        check("reset_pending", bus.pending, 0);
        reset_n = 1'b1;

        // Mode 0 with all inputs low never passes; each trigger keeps busy for two cycles.
        drive(2'b00, 2'd0, 1'b0);
        repeat (3) tick();
        clear_counts(); cnt_en = 1;
        for (int t = 0; t < 5; t++) begin
            bus.fault_in = 1'b1; tick(); bus.fault_in = 1'b0;
            repeat (9) tick();
        end
        cnt_en = 0;
        check("m0_out_pulses", out_cnt, 0);
        check("m0_busy_cycles", busy_cnt, 10);
        check("m0_pending_end", bus.pending, 0);
        $display("txn mode0-zero: 5 triggers, busy cycles %0d, pulses %0d", busy_cnt, out_cnt);

        // Fill the queue to 3, then assert the asynchronous reset mid-cycle.
        bus.fault_in = 1'b1;
        repeat (5) tick();
        check("rst_pre_pending", bus.pending, 3);
        bus.fault_in = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_out", bus.out, 0);
        check("rst_async_pending", bus.pending, 0);
        check("rst_async_busy", bus.busy, 0);
        check("rst_async_overflow", bus.overflow, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        $display("txn async reset with pending 3");

        // Mode 1 timing: a trigger at edge t pulses out during the cycle after t+2 only.
        drive(2'b11, 2'd1, 1'b0);
        repeat (3) tick();
        pattern = 0;
        bus.fault_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.fault_in = 1'b0;
            pattern |= int'(bus.out) << i;
        end
`ifdef GATE_FAULT_DET_MODES_EN
        check("m1_pulse_timing", pattern, 4);
`endif
        drive(2'b01, 2'd1, 1'b0);
        repeat (3) tick();
        pattern = 0;
        bus.fault_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.fault_in = 1'b0;
            pattern |= int'(bus.out) << i;
        end
`ifdef GATE_FAULT_DET_MODES_EN
        check("m1_fail_no_pulse", pattern, 0);
`endif
        $display("txn mode1 timing pattern %0d", pattern);

        // Mode 2 saturation: 12 back-to-back triggers, 4 of them dropped.
        drive(2'b01, 2'd2, 1'b0);
        wait_idle(0);
        repeat (3) tick();
        clear_counts(); cnt_en = 1;
        bus.fault_in = 1'b1;
        repeat (12) tick();
        bus.fault_in = 1'b0;
        repeat (40) tick();
        cnt_en = 0;
        check("m2_max_pending", max_pend, 4);
        check("m2_overflow", bus.overflow, 1);
`ifdef GATE_FAULT_DET_MODES_EN
        check("m2_pulse_count", out_cnt, 8);
        spacing_ok = 1;
        for (int i = 1; i < pulse_at.size(); i++)
            if (pulse_at[i] - pulse_at[i-1] != 3) spacing_ok = 0;
        check("m2_pulse_spacing", spacing_ok, 1);
`endif
        $display("txn mode2 burst: pulses %0d max pending %0d", out_cnt, max_pend);

        // logic_reset while evaluating with 3 queued and a same-cycle trigger.
        wait_idle(0);
        repeat (2) tick();
        bus.fault_in = 1'b1;
        repeat (5) tick();
`ifdef GATE_FAULT_DET_MODES_EN
        check("lr_pre_pending", bus.pending, 3);
`endif
        lrst = 1'b1;
        tick();
        lrst = 1'b0; bus.fault_in = 1'b0;
        check("lr_pending", bus.pending, 0);
        check("lr_out", bus.out, 0);
        check("lr_overflow", bus.overflow, 0);
        check("lr_busy", bus.busy, 0);
        clear_counts(); cnt_en = 1;
        repeat (10) tick();
        cnt_en = 0;
        check("lr_no_pulses", out_cnt, 0);
        $display("txn logic_reset during eval");

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(2'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0));
            lrst = ($urandom_range(0, 60) == 0);
            tick();
        end
        lrst = 1'b0; bus.fault_in = 1'b0;
        $display("txn random traffic: 3000 cycles");

        // Weighted-random pass rate with half the inputs high on identical-seed instances.
        bus4a.in = 4'b0011; bus4b.in = 4'b0011;
        repeat (3) tick();
        rate_cnt = 0; rate_en = 1;
        for (int n = 0; n < 4095; n++) begin
            bus4a.fault_in = 1'b1; bus4b.fault_in = 1'b1;
            tick();
            bus4a.fault_in = 1'b0; bus4b.fault_in = 1'b0;
            wait_idle(1);
            repeat ($urandom_range(0, 3)) tick();
        end
        rate_en = 0;
        check("rate_low_bound", (rate_cnt * 100 >= 47 * 4095), 1);
        check("rate_high_bound", (rate_cnt * 100 <= 53 * 4095), 1);
        $display("txn pass rate: %0d of 4095", rate_cnt);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
